// File: rtl/aq_gemac_pkg.sv
// Shared constants and encodings for the GEMAC PHY management sequencer.
// Optional feature macro: AQ_GEMAC_PHY_POLL_SPEED_EN (adds the PSSR read per poll).
package aq_gemac_pkg;

  // MII register addresses
  localparam logic [4:0] MII_REG_BMSR = 5'd1;
  localparam logic [4:0] MII_REG_PSSR = 5'd17;

  // Register bit positions
  localparam int BMSR_LINK_BIT     = 2;
  localparam int PSSR_SPEED_HI     = 15;
  localparam int PSSR_SPEED_LO     = 14;
  localparam int PSSR_DUPLEX_BIT   = 13;
  localparam int PSSR_RESOLVED_BIT = 11;

  // SPEED output encodings
  localparam logic [1:0] SPEED_10M   = 2'b00;
  localparam logic [1:0] SPEED_100M  = 2'b01;
  localparam logic [1:0] SPEED_1000M = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_UPDATE    = 3'd4
  } state_t;

`ifdef AQ_GEMAC_PHY_POLL_SPEED_EN
  typedef enum logic [1:0] {
    OP_HOST = 2'd0,
    OP_BMSR = 2'd1,
    OP_PSSR = 2'd2
  } op_kind_t;
`else
  typedef enum logic [1:0] {
    OP_HOST = 2'd0,
    OP_BMSR = 2'd1
  } op_kind_t;
`endif

  // The reserved PSSR speed code 2'b11 is reported as gigabit.
  function automatic logic [1:0] decode_speed(input logic [1:0] raw);
    decode_speed = (raw == 2'b11) ? SPEED_1000M : raw;
  endfunction

endpackage

// File: rtl/aq_gemac_poll_timer.sv
// Poll interval counter with a saturating single-entry poll_pending flag.
module aq_gemac_poll_timer #(
  parameter logic [31:0] POLL_INTERVAL = 32'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic poll_pending
);

  logic [31:0] count;

  // Count while enabled; a wrap raises pending and wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= 32'd0;
      poll_pending <= 1'b0;
    end else if (!enable) begin
      count        <= 32'd0;
      poll_pending <= 1'b0;
    end else if (count >= POLL_INTERVAL - 32'd1) begin
      count        <= 32'd0;
      poll_pending <= 1'b1;
    end else begin
      count <= count + 32'd1;
      if (clear) begin
        poll_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aq_gemac_phy_poll.sv
// PHY status poller and host-access arbiter in front of the single MIIM master.
// Optional feature macro: AQ_GEMAC_PHY_POLL_SPEED_EN (BMSR then PSSR per poll).
module aq_gemac_phy_poll
  import aq_gemac_pkg::*;
#(
  parameter logic [31:0] POLL_INTERVAL = 32'd1000000,
  parameter logic [4:0]  PHY_ADDR      = 5'd1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        HOST_REQUEST,
  input  logic        HOST_WRITE,
  input  logic [4:0]  HOST_REG_ADDRESS,
  input  logic [15:0] HOST_WDATA,
  output logic [15:0] HOST_RDATA,
  output logic        HOST_BUSY,
  output logic        HOST_DONE,
  output logic        MIIM_REQUEST,
  output logic        MIIM_WRITE,
  output logic [4:0]  MIIM_PHY_ADDRESS,
  output logic [4:0]  MIIM_REG_ADDRESS,
  output logic [15:0] MIIM_WDATA,
  input  logic [15:0] MIIM_RDATA,
  input  logic        MIIM_BUSY,
  output logic        LINK_UP,
  output logic [1:0]  SPEED,
  output logic        FULL_DUPLEX,
  output logic        STATUS_VALID,
  output logic        LINK_CHANGE
);

  // The request cycle plus seven waiting cycles gives an 8-cycle retry spacing.
  localparam logic [2:0] WAIT_LAST = 3'd6;
  localparam logic [1:0] MAX_RETRY = 2'd3;

  state_t      state;
  op_kind_t    op;
  logic [15:0] rdata_q;
  logic [2:0]  wait_cnt;
  logic [1:0]  retry_cnt;
  logic        aborted;
  logic        poll_pending;
  logic        poll_clear;
`ifdef AQ_GEMAC_PHY_POLL_SPEED_EN
  logic        link_q;
`endif

  // A pending poll is consumed only when the host is not claiming the idle slot.
  assign poll_clear = (state == S_IDLE) && !HOST_REQUEST && poll_pending;

  aq_gemac_poll_timer #(
    .POLL_INTERVAL(POLL_INTERVAL)
  ) u_timer (
    .clk          (CLK),
    .rst          (RST),
    .enable       (ENABLE),
    .clear        (poll_clear),
    .poll_pending (poll_pending)
  );

  // Sequencer: arbitration, MIIM handshake with retry/abort, status decode and commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= S_IDLE;
      op               <= OP_HOST;
      rdata_q          <= 16'd0;
      wait_cnt         <= 3'd0;
      retry_cnt        <= 2'd0;
      aborted          <= 1'b0;
      HOST_RDATA       <= 16'd0;
      HOST_BUSY        <= 1'b0;
      HOST_DONE        <= 1'b0;
      MIIM_REQUEST     <= 1'b0;
      MIIM_WRITE       <= 1'b0;
      MIIM_PHY_ADDRESS <= PHY_ADDR;
      MIIM_REG_ADDRESS <= 5'd0;
      MIIM_WDATA       <= 16'd0;
      LINK_UP          <= 1'b0;
      SPEED            <= SPEED_10M;
      FULL_DUPLEX      <= 1'b0;
      STATUS_VALID     <= 1'b0;
      LINK_CHANGE      <= 1'b0;
`ifdef AQ_GEMAC_PHY_POLL_SPEED_EN
      link_q           <= 1'b0;
`endif
    end else begin
      HOST_DONE        <= 1'b0;
      LINK_CHANGE      <= 1'b0;
      MIIM_PHY_ADDRESS <= PHY_ADDR;
      case (state)
        S_IDLE: begin
          if (HOST_REQUEST) begin
            op               <= OP_HOST;
            HOST_BUSY        <= 1'b1;
            MIIM_WRITE       <= HOST_WRITE;
            MIIM_REG_ADDRESS <= HOST_REG_ADDRESS;
            MIIM_WDATA       <= HOST_WDATA;
            MIIM_REQUEST     <= !MIIM_BUSY;
            retry_cnt        <= 2'd0;
            state            <= S_ISSUE;
          end else if (poll_pending) begin
            op               <= OP_BMSR;
            MIIM_WRITE       <= 1'b0;
            MIIM_REG_ADDRESS <= MII_REG_BMSR;
            MIIM_WDATA       <= 16'd0;
            MIIM_REQUEST     <= !MIIM_BUSY;
            retry_cnt        <= 2'd0;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The request is held for exactly the one cycle in which it is visible.
          if (MIIM_REQUEST) begin
            MIIM_REQUEST <= 1'b0;
            wait_cnt     <= 3'd0;
            state        <= S_WAIT_BUSY;
          end else if (!MIIM_BUSY) begin
            MIIM_REQUEST <= 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          if (MIIM_BUSY) begin
            state <= S_WAIT_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            if (retry_cnt == MAX_RETRY) begin
              aborted <= 1'b1;
              state   <= S_UPDATE;
            end else begin
              retry_cnt    <= retry_cnt + 2'd1;
              MIIM_REQUEST <= 1'b1;
              state        <= S_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!MIIM_BUSY) begin
            rdata_q <= MIIM_RDATA;
            aborted <= 1'b0;
            state   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          state <= S_IDLE;
          case (op)
            OP_HOST: begin
              HOST_RDATA <= aborted ? 16'hFFFF : rdata_q;
              HOST_DONE  <= 1'b1;
              HOST_BUSY  <= 1'b0;
            end
`ifdef AQ_GEMAC_PHY_POLL_SPEED_EN
            OP_BMSR: begin
              // The PSSR read follows directly so the pair is never split.
              if (!aborted) begin
                link_q           <= rdata_q[BMSR_LINK_BIT];
                op               <= OP_PSSR;
                MIIM_WRITE       <= 1'b0;
                MIIM_REG_ADDRESS <= MII_REG_PSSR;
                MIIM_WDATA       <= 16'd0;
                MIIM_REQUEST     <= !MIIM_BUSY;
                retry_cnt        <= 2'd0;
                state            <= S_ISSUE;
              end
            end
            OP_PSSR: begin
              if (!aborted) begin
                if (rdata_q[PSSR_RESOLVED_BIT]) begin
                  SPEED       <= decode_speed(rdata_q[PSSR_SPEED_HI:PSSR_SPEED_LO]);
                  FULL_DUPLEX <= rdata_q[PSSR_DUPLEX_BIT];
                end
                LINK_UP      <= link_q;
                LINK_CHANGE  <= (link_q != LINK_UP);
                STATUS_VALID <= 1'b1;
              end
            end
`else
            OP_BMSR: begin
              if (!aborted) begin
                LINK_UP      <= rdata_q[BMSR_LINK_BIT];
                LINK_CHANGE  <= (rdata_q[BMSR_LINK_BIT] != LINK_UP);
                STATUS_VALID <= 1'b1;
                SPEED        <= SPEED_1000M;
                FULL_DUPLEX  <= 1'b1;
              end
            end
`endif
            default: begin
              HOST_BUSY <= 1'b0;
            end
          endcase
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aq_gemac_phy_poll.sv
// Randomized bench: behavioural MIIM responder plus a status reference model.
module tb_aq_gemac_phy_poll;

`ifdef AQ_GEMAC_PHY_POLL_SPEED_EN
  localparam int POLL_TXN    = 2;
  localparam bit SPEED_BUILD = 1'b1;
`else
  localparam int POLL_TXN    = 1;
  localparam bit SPEED_BUILD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ENABLE, HOST_REQUEST, HOST_WRITE;
  logic [4:0]  HOST_REG_ADDRESS;
  logic [15:0] HOST_WDATA, HOST_RDATA;
  logic        HOST_BUSY, HOST_DONE, MIIM_REQUEST, MIIM_WRITE;
  logic [4:0]  MIIM_PHY_ADDRESS, MIIM_REG_ADDRESS;
  logic [15:0] MIIM_WDATA, MIIM_RDATA;
  logic        MIIM_BUSY, LINK_UP, FULL_DUPLEX, STATUS_VALID, LINK_CHANGE;
  logic [1:0]  SPEED;

  aq_gemac_phy_poll #(.POLL_INTERVAL(32'd100), .PHY_ADDR(5'd1)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
    .HOST_REQUEST(HOST_REQUEST), .HOST_WRITE(HOST_WRITE),
    .HOST_REG_ADDRESS(HOST_REG_ADDRESS), .HOST_WDATA(HOST_WDATA),
    .HOST_RDATA(HOST_RDATA), .HOST_BUSY(HOST_BUSY), .HOST_DONE(HOST_DONE),
    .MIIM_REQUEST(MIIM_REQUEST), .MIIM_WRITE(MIIM_WRITE),
    .MIIM_PHY_ADDRESS(MIIM_PHY_ADDRESS), .MIIM_REG_ADDRESS(MIIM_REG_ADDRESS),
    .MIIM_WDATA(MIIM_WDATA), .MIIM_RDATA(MIIM_RDATA), .MIIM_BUSY(MIIM_BUSY),
    .LINK_UP(LINK_UP), .SPEED(SPEED), .FULL_DUPLEX(FULL_DUPLEX),
    .STATUS_VALID(STATUS_VALID), .LINK_CHANGE(LINK_CHANGE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // MIIM responder state
  typedef struct { bit wr; logic [4:0] ra; logic [15:0] wd; int t; } txn_t;
  txn_t        log_q[$];
  logic [15:0] regs [32];
  logic [15:0] bmsr_val, pssr_val, next_rdata;
  bit          mute, long_busy, prev_req;
  int          busy_left, cyc, req_count, done_count, lc_count, hd_count, proto_err;
  int          fall_cyc, done_cyc;

  // Reference status
  logic       exp_link, exp_fd, exp_valid;
  logic [1:0] exp_speed;
  int         exp_lc;

  initial begin
    MIIM_BUSY = 1'b0; MIIM_RDATA = 16'd0; busy_left = 0; cyc = 0;
    req_count = 0; done_count = 0; lc_count = 0; hd_count = 0; proto_err = 0;
    fall_cyc = 0; done_cyc = 0; prev_req = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 16'($urandom);
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        busy_left = 0; MIIM_BUSY = 1'b0; prev_req = 1'b0;
      end else begin
        if (LINK_CHANGE) lc_count++;
        if (HOST_DONE) begin
          hd_count++; done_cyc = cyc;
          if (HOST_BUSY) proto_err++;
        end
        if (MIIM_REQUEST) begin
          txn_t tx;
          req_count++;
          if (MIIM_BUSY || prev_req || MIIM_PHY_ADDRESS != 5'd1) proto_err++;
          tx.wr = MIIM_WRITE; tx.ra = MIIM_REG_ADDRESS; tx.wd = MIIM_WDATA; tx.t = cyc;
          log_q.push_back(tx);
          if (!mute) begin
            if (MIIM_WRITE) begin
              regs[MIIM_REG_ADDRESS] = MIIM_WDATA;
              next_rdata = 16'($urandom);
            end else if (MIIM_REG_ADDRESS == 5'd1) next_rdata = bmsr_val;
            else if (MIIM_REG_ADDRESS == 5'd17) next_rdata = pssr_val;
            else next_rdata = regs[MIIM_REG_ADDRESS];
            busy_left = long_busy ? 20 : int'($urandom_range(6, 2));
            MIIM_BUSY = 1'b1;
          end
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            MIIM_BUSY = 1'b0; MIIM_RDATA = next_rdata; done_count++; fall_cyc = cyc;
          end
        end
        prev_req = MIIM_REQUEST;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected status after a completed poll, from the register bit rules.
  task automatic model_poll(input logic [15:0] b, input logic [15:0] p);
    if (SPEED_BUILD) begin
      if (p[11]) begin
        exp_speed = (p[15:14] == 2'b11) ? 2'b10 : p[15:14];
        exp_fd    = p[13];
      end
    end else begin
      exp_speed = 2'b10; exp_fd = 1'b1;
    end
    if (b[2] != exp_link) exp_lc++;
    exp_link  = b[2];
    exp_valid = 1'b1;
  endtask

  task automatic wait_done_txn(input string tag, input int target, input int budget);
    int k = 0;
    while (done_count < target && k < budget) begin @(negedge CLK); k++; end
    if (done_count < target) check_eq({tag, "_timeout"}, done_count, target);
    repeat (4) @(negedge CLK);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_link"},   LINK_UP,      exp_link);
    check_eq({tag, "_speed"},  SPEED,        exp_speed);
    check_eq({tag, "_duplex"}, FULL_DUPLEX,  exp_fd);
    check_eq({tag, "_valid"},  STATUS_VALID, exp_valid);
    check_eq({tag, "_lchg"},   lc_count,     exp_lc);
  endtask

  task automatic run_poll(input string tag, input logic [15:0] b, input logic [15:0] p);
    int d0 = done_count;
    bmsr_val = b; pssr_val = p;
    model_poll(b, p);
    wait_done_txn(tag, d0 + POLL_TXN, 300);
    check_status(tag);
  endtask

  // Caller must be at a negedge; returns accept latency and MIIM_REQUEST at acceptance.
  task automatic host_op(input string tag, input bit wr, input logic [4:0] a,
                         input logic [15:0] d, input int budget,
                         output int lat, output logic req_seen);
    int k = 0;
    int hd0 = hd_count;
    HOST_REQUEST = 1'b1; HOST_WRITE = wr; HOST_REG_ADDRESS = a; HOST_WDATA = d;
    while (!HOST_BUSY && k < budget) begin @(negedge CLK); k++; end
    lat = k; req_seen = MIIM_REQUEST;
    HOST_REQUEST = 1'b0;
    while (hd_count == hd0 && k < budget) begin @(negedge CLK); k++; end
    if (hd_count == hd0) check_eq({tag, "_timeout"}, hd_count, hd0 + 1);
    @(negedge CLK);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_mreq"},  MIIM_REQUEST,     1'b0);
    check_eq({tag, "_mwr"},   MIIM_WRITE,       1'b0);
    check_eq({tag, "_hbusy"}, HOST_BUSY,        1'b0);
    check_eq({tag, "_hdone"}, HOST_DONE,        1'b0);
    check_eq({tag, "_link"},  LINK_UP,          1'b0);
    check_eq({tag, "_valid"}, STATUS_VALID,     1'b0);
    check_eq({tag, "_lchg"},  LINK_CHANGE,      1'b0);
    check_eq({tag, "_fd"},    FULL_DUPLEX,      1'b0);
    check_eq({tag, "_speed"}, SPEED,            2'b00);
    check_eq({tag, "_hrd"},   HOST_RDATA,       16'h0000);
    check_eq({tag, "_mwd"},   MIIM_WDATA,       16'h0000);
    check_eq({tag, "_mra"},   MIIM_REG_ADDRESS, 5'd0);
    check_eq({tag, "_phy"},   MIIM_PHY_ADDRESS, 5'd1);
  endtask

  initial begin
    int lat, r0, i0, d0, k;
    logic rq;
    logic [4:0] ra;
    ENABLE = 1'b0; HOST_REQUEST = 1'b0; HOST_WRITE = 1'b0;
    HOST_REG_ADDRESS = 5'd0; HOST_WDATA = 16'd0;
    mute = 1'b0; long_busy = 1'b0; bmsr_val = 16'd0; pssr_val = 16'd0;
    exp_link = 1'b0; exp_fd = 1'b0; exp_valid = 1'b0; exp_speed = 2'b00; exp_lc = 0;

    repeat (3) @(negedge CLK);
    check_reset("rst0");
    RST = 1'b0;
    @(negedge CLK);
    ENABLE = 1'b1;

    // Link up, link down, and a repeated link-down value with no pulse
    run_poll("p1", 16'h0004, 16'hA800);
    run_poll("p2", 16'h0000, 16'hA800);
    run_poll("p3", 16'h7800, 16'h2000);

    // Host write on an idle sequencer, then read it back
    i0 = log_q.size(); r0 = req_count; d0 = hd_count;
    host_op("hw", 1'b1, 5'd0, 16'h8000, 100, lat, rq);
    check_eq("hw_accept_lat", lat, 1);
    check_eq("hw_req_at_busy", rq, 1'b1);
    check_eq("hw_nreq", req_count - r0, 1);
    check_eq("hw_ndone", hd_count - d0, 1);
    check_eq("hw_txn_wr", (log_q.size() > i0) ? log_q[i0].wr : 1'b0, 1'b1);
    check_eq("hw_txn_reg", (log_q.size() > i0) ? log_q[i0].ra : 5'h1F, 5'd0);
    check_eq("hw_txn_data", (log_q.size() > i0) ? log_q[i0].wd : 16'h0, 16'h8000);
    check_eq("hw_done_lat", done_cyc - fall_cyc, 2);
    host_op("hr", 1'b0, 5'd0, 16'h0000, 100, lat, rq);
    check_eq("hr_rdata", HOST_RDATA, 16'h8000);

    // Randomized poll results
    for (int n = 0; n < 6; n++) begin
      run_poll($sformatf("rnd%0d", n), 16'($urandom), 16'($urandom));
    end

    // Host read arriving in the same cycle the poll becomes due
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    bmsr_val = 16'h0004; pssr_val = 16'h6800;
    model_poll(bmsr_val, pssr_val);
    d0 = done_count; i0 = log_q.size();
    ENABLE = 1'b1;
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    host_op("hp", 1'b0, 5'd5, 16'h0000, 200, lat, rq);
    wait_done_txn("hp_poll", d0 + 1 + POLL_TXN, 300);
    check_eq("hp_rdata", HOST_RDATA, regs[5]);
    check_eq("hp_ntxn", log_q.size() - i0, 1 + POLL_TXN);
    check_eq("hp_first_reg", (log_q.size() > i0) ? log_q[i0].ra : 5'h1F, 5'd5);
    for (int j = 1; j <= POLL_TXN; j++) begin
      ra = (log_q.size() > i0 + j) ? log_q[i0 + j].ra : 5'h1F;
      check_eq($sformatf("hp_poll_reg%0d", j), ra, (j == 1) ? 5'd1 : 5'd17);
    end
    check_status("hp");

    // MIIM master never responds: four requests, then abort data
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    mute = 1'b1; r0 = req_count; i0 = log_q.size();
    host_op("ab", 1'b0, 5'd3, 16'h0000, 300, lat, rq);
    check_eq("ab_nreq", req_count - r0, 4);
    for (int j = 0; j < 3; j++) begin
      k = (log_q.size() > i0 + j + 1) ? (log_q[i0 + j + 1].t - log_q[i0 + j].t) : -1;
      check_eq($sformatf("ab_spacing%0d", j), k, 8);
    end
    check_eq("ab_rdata", HOST_RDATA, 16'hFFFF);
    mute = 1'b0;

    // Reset while the MIIM master is busy, then a normal poll
    ENABLE = 1'b1;
    run_poll("pre", 16'h0004 | 16'($urandom), 16'hA800);
    long_busy = 1'b1; r0 = req_count; k = 0;
    while (req_count == r0 && k < 300) begin @(negedge CLK); k++; end
    if (req_count == r0) check_eq("rst_wait_timeout", req_count, r0 + 1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset("rst1");
    RST = 1'b0; long_busy = 1'b0;
    exp_link = 1'b0; exp_valid = 1'b0; exp_speed = 2'b00; exp_fd = 1'b0;
    run_poll("post", 16'h0004, 16'hA800);

    check_eq("protocol", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
